reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Sits directly downstream of the PLL clock generator and runs in the PLL output clock domain.
- Takes the already-synchronised lock flag and turns it into a clean system reset for the rest of the design.
- The lock must hold continuously for a stability window before a fixed-length reset pulse is issued.
- Also handles user reset requests and lock-loss recovery, and counts lock drops for diagnostics.

Parameters:
- LOCK_CYCLES, 1024: consecutive locked cycles required before reset sequencing starts; must be >=1.
- RST_CYCLES, 16: length of the system reset pulse in clk cycles; must be >=1.
- DROP_W, 8: width of the lock-drop counter.

Ports:
- clk  input  1  PLL output clock; all logic is in this domain.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- clk_locked  input  1  PLL lock, already synchronised to clk.
- req_rst  input  1  asynchronous user reset request (e.g. button), level, active-high.
- sys_rst  output  1  registered active-high system reset.
- sys_rst_n  output  1  registered inverse of sys_rst.
- ready  output  1  high only in RUN.
- lock_lost  output  1  sticky: set on any lock drop while in HOLD or RUN.
- drop_count  output  DROP_W  saturating count of lock drops in HOLD or RUN.

Behaviour:
- Reset (rst_n low):
  - Asynchronously forces state WAIT_LOCK and counter 0.
  - Outputs: sys_rst=1, sys_rst_n=0, ready=0, lock_lost=0, drop_count=0.
  - req_rst synchroniser and edge flop are cleared to 0.
- req_rst handling:
  - Passes through a 2-FF synchroniser, then a rising-edge detector (req_pulse).
  - Effective latency: 3 clk edges from an input rise to the state machine acting on it.
  - Held level produces only one pulse.
- Registered outputs:
  - sys_rst = (next_state != RUN); ready = (next_state == RUN).
  - All outputs are registered; no combinational path from inputs to outputs.
- States and transitions:
  - WAIT_LOCK: clk_locked=1 -> STABLE, counter=0. Otherwise stay.
  - STABLE:
    - clk_locked=0 -> WAIT_LOCK; lock_lost and drop_count unchanged.
    - Else if counter==LOCK_CYCLES-1 -> HOLD, counter=0.
    - Else counter+1.
  - HOLD:
    - clk_locked=0 -> WAIT_LOCK; lock_lost=1; drop_count+1.
    - Else if req_pulse -> stay in HOLD, counter=0 (restart pulse).
    - Else if counter==RST_CYCLES-1 -> RUN.
    - Else counter+1.
  - RUN:
    - clk_locked=0 -> WAIT_LOCK; sys_rst=1 on that same edge; lock_lost=1; drop_count+1.
    - Else if req_pulse -> HOLD, counter=0. The stability window is skipped because lock is still good.
- Timing:
  - Call the first edge sampling clk_locked=1 in WAIT_LOCK edge 1.
  - With lock held, sys_rst falls and ready rises on edge LOCK_CYCLES+RST_CYCLES+1.
- Simultaneous events:
  - Lock drop and req_pulse on the same edge: lock drop wins.
  - req_pulse in WAIT_LOCK or STABLE is ignored; reset is already asserted and a pulse will follow.
- drop_count saturates at 2^DROP_W-1 and never wraps.
- Counter width is $clog2 of the larger of LOCK_CYCLES and RST_CYCLES, minimum 1 bit.
- Only rst_n clears lock_lost and drop_count; a user request does not.
- rst_n asserted mid-sequence aborts immediately. After release the sequence restarts from WAIT_LOCK.

Test Plan (LOCK_CYCLES=8, RST_CYCLES=4, DROP_W=2):
- Power-up: rst_n low 3 cycles, then clk_locked=1 from edge 1 -> sys_rst=1, ready=0 through edge 12; sys_rst=0, sys_rst_n=1, ready=1 at edge 13.
- Glitchy lock: clk_locked high 5 cycles, low 1, then high -> window restarts; ready at edge 13 counted from the re-rise; lock_lost=0, drop_count=0.
- Lock loss in RUN: drop clk_locked for 1 cycle -> sys_rst=1 on the next edge, lock_lost=1, drop_count=1; ready returns 13 edges after lock returns.
- User reset in RUN: req_rst high for 10 cycles -> sys_rst rises 3 edges after the rise and lasts exactly 4 cycles; only one pulse; drop_count unchanged.
- Saturation: 5 lock drops in RUN -> drop_count=3 and stays 3; lock_lost stays 1 until rst_n.
- Simultaneous events and mid-sequence reset:
  - req_pulse and lock drop on the same edge in RUN -> WAIT_LOCK, drop_count+1.
  - rst_n pulsed during HOLD -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/reset_sequencer.sv
// Turns a synchronised PLL lock flag and user requests into a clean registered system reset.
// Latency: sys_rst/ready update on the edge that decides the next state; req_rst acts on its 3rd edge.
// No backpressure: free-running sequencer, outputs are levels.
module reset_sequencer #(
    parameter int LOCK_CYCLES = 1024,
    parameter int RST_CYCLES  = 16,
    parameter int DROP_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_locked,
    input  logic              req_rst,
    output logic              sys_rst,
    output logic              sys_rst_n,
    output logic              ready,
    output logic              lock_lost,
    output logic [DROP_W-1:0] drop_count
);

    localparam int CNT_MAX = (LOCK_CYCLES > RST_CYCLES) ? LOCK_CYCLES : RST_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE  = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_SAT  = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        HOLD,
        RUN
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             drop_evt;

    logic req_meta;
    logic req_sync;
    logic req_d;
    logic req_pulse;

    // req_rst is asynchronous to clk: two flops to settle, a third for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta <= 1'b0;
            req_sync <= 1'b0;
            req_d    <= 1'b0;
        end else begin
            req_meta <= req_rst;
            req_sync <= req_meta;
            req_d    <= req_sync;
        end
    end

    assign req_pulse = req_sync & ~req_d;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        drop_evt   = 1'b0;
        unique case (state)
            WAIT_LOCK: begin
                if (clk_locked) begin
                    next_state = STABLE;
                    next_cnt   = '0;
                end
            end
            STABLE: begin
                // a drop before the window completes is not a loss of an established lock
                if (!clk_locked) begin
                    next_state = WAIT_LOCK;
                end else if (cnt == LOCK_LAST) begin
                    next_state = HOLD;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end
            HOLD: begin
                if (!clk_locked) begin
                    next_state = WAIT_LOCK;
                    drop_evt   = 1'b1;
                end else if (req_pulse) begin
                    next_cnt = '0;
                end else if (cnt == RST_LAST) begin
                    next_state = RUN;
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end
            RUN: begin
                // lock still good on a user request, so the stability window is skipped
                if (!clk_locked) begin
                    next_state = WAIT_LOCK;
                    drop_evt   = 1'b1;
                end else if (req_pulse) begin
                    next_state = HOLD;
                    next_cnt   = '0;
                end
            end
            default: begin
                next_state = WAIT_LOCK;
                next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // outputs follow next_state so they change on the same edge as the decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
        end else begin
            sys_rst   <= (next_state != RUN);
            sys_rst_n <= (next_state == RUN);
            ready     <= (next_state == RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost  <= 1'b0;
            drop_count <= '0;
        end else if (drop_evt) begin
            lock_lost <= 1'b1;
            if (drop_count != DROP_SAT) begin
                drop_count <= drop_count + DROP_ONE;
            end
        end
    end

endmodule
